// File: rtl/mcycle_unit.sv
// mcycle_unit: iterative unsigned multiply / divide unit for the EX stage.
//
// A started operation runs for exactly WIDTH iterations, one per clock. Multiply
// uses a radix-2 shift-add over a 2*WIDTH-bit product. Divide uses restoring
// division, producing one quotient bit per iteration, MSB first. Busy stalls
// the pipeline from the cycle Start is first seen until the last iteration.
// The results are loaded only at completion and then hold until the next
// completion or reset.
//
// Ports:
//   CLK       in   system clock, rising edge
//   RESET     in   asynchronous reset, active high
//   Start     in   request a new operation (sampled only in IDLE)
//   MCycleOp  in   0 = unsigned multiply, 1 = unsigned divide
//   Operand1  in   multiplicand / dividend
//   Operand2  in   multiplier / divisor
//   Result1   out  multiply: low product word;  divide: quotient
//   Result2   out  multiply: high product word; divide: remainder
//   Busy      out  stall request (combinational)
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | waiting for Start; results hold
// COMPUTING  | one iteration per cycle, counter 0..WIDTH-1
// DONE       | one-cycle cool-down, Start ignored so a held Start does not
//            | re-trigger while the stalled instruction advances

module mcycle_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             Start,
    input  logic             MCycleOp,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    output logic             Busy
);

    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_COMPUTING = 2'd1,
        ST_DONE      = 2'd2
    } state_t;

    state_t               state_q,   state_d;
    logic [CNT_W-1:0]     cnt_q,     cnt_d;
    logic                 div_q,     div_d;
    logic [WIDTH-1:0]     opnd_q,    opnd_d;
    logic [2*WIDTH-1:0]   acc_q,     acc_d;
    logic [WIDTH-1:0]     result1_q, result1_d;
    logic [WIDTH-1:0]     result2_q, result2_d;

    // The accumulator is a single 2*WIDTH shift register shared by both
    // operations. Its low half starts as the word that gets consumed bit by
    // bit (multiplier or dividend) and ends up holding the low product word
    // or the quotient; its high half is the running partial product or the
    // partial remainder. opnd_q holds the other operand (multiplicand or
    // divisor) for the whole operation.
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_shift;
    logic                 div_ge;
    logic [WIDTH-1:0]     div_rem;
    logic [2*WIDTH-1:0]   div_next;
    logic [2*WIDTH-1:0]   step_acc;

    always_comb begin
        // Multiply: add the multiplicand into the high half when the current
        // multiplier bit is set, then shift the whole product right by one.
        // The carry out of the add becomes the new product MSB.
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                 + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};

        // Divide: shift the next dividend bit into the partial remainder and
        // subtract the divisor if it fits. The remainder before the shift is
        // always below the divisor, so the restored value fits in WIDTH bits.
        // A zero divisor always "fits", giving an all-ones quotient and the
        // dividend as remainder without any special case.
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opnd_q});
        div_rem   = div_ge ? WIDTH'(div_shift - {1'b0, opnd_q})
                           : div_shift[WIDTH-1:0];
        div_next  = {div_rem, acc_q[WIDTH-2:0], div_ge};

        step_acc  = div_q ? div_next : mul_next;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        result1_d = result1_q;
        result2_d = result2_q;
        Busy      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    Busy    = 1'b1;
                    div_d   = MCycleOp;
                    opnd_d  = MCycleOp ? Operand2 : Operand1;
                    acc_d   = {{WIDTH{1'b0}}, (MCycleOp ? Operand1 : Operand2)};
                    cnt_d   = '0;
                    state_d = ST_COMPUTING;
                end
            end

            ST_COMPUTING: begin
                Busy  = 1'b1;
                acc_d = step_acc;
                if (cnt_q == CNT_LAST) begin
                    // Exit before the counter can wrap; it simply holds.
                    result1_d = step_acc[WIDTH-1:0];
                    result2_d = step_acc[2*WIDTH-1:WIDTH];
                    state_d   = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            div_q     <= 1'b0;
            opnd_q    <= '0;
            acc_q     <= '0;
            result1_q <= '0;
            result2_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            result1_q <= result1_d;
            result2_q <= result2_d;
        end
    end

    assign Result1 = result1_q;
    assign Result2 = result2_q;

endmodule

// File: tb/tb_mcycle_unit.sv
module tb_mcycle_unit;

    localparam int W = 32;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         Start;
    logic         MCycleOp;
    logic [W-1:0] Operand1;
    logic [W-1:0] Operand2;
    logic [W-1:0] Result1;
    logic [W-1:0] Result2;
    logic         Busy;

    int compared   = 0;
    int mismatched = 0;

    always #5 CLK = ~CLK;

    mcycle_unit #(.WIDTH(W)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .Start    (Start),
        .MCycleOp (MCycleOp),
        .Operand1 (Operand1),
        .Operand2 (Operand2),
        .Result1  (Result1),
        .Result2  (Result2),
        .Busy     (Busy)
    );

    // Reference: {Result2, Result1} from plain arithmetic.
    function automatic logic [63:0] model(input logic op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] p;
        if (!op)
            p = {32'h0, a} * {32'h0, b};
        else if (b == 32'h0)
            p = {a, 32'hFFFF_FFFF};
        else
            p = {a % b, a / b};
        return p;
    endfunction

    function automatic logic [31:0] pick_operand();
        logic [31:0] v;
        case ($urandom_range(0, 4))
            0:       v = $urandom;
            1:       v = $urandom_range(0, 20);
            2:       v = 32'hFFFF_FFFF - $urandom_range(0, 3);
            3:       v = 32'h1 << $urandom_range(0, 31);
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Drive a request at the negedge of cycle 0.
    task automatic issue(input logic op, input logic [31:0] a, input logic [31:0] b);
        @(negedge CLK);
        Start    = 1'b1;
        MCycleOp = op;
        Operand1 = a;
        Operand2 = b;
    endtask

    // Starting in cycle 0, count Busy cycles until Busy drops (bounded).
    // Returns sitting in the DONE cycle, just after its negedge.
    task automatic wait_done(input bit hold, input bit scramble, output int busy_cyc,
                             output bit leaked, output bit done);
        logic [31:0] r1s, r2s;
        #1;
        r1s      = Result1;
        r2s      = Result2;
        leaked   = 1'b0;
        done     = 1'b0;
        busy_cyc = Busy ? 1 : 0;
        for (int i = 0; i < 80 && !done; i++) begin
            @(negedge CLK);
            if (!hold) Start = 1'b0;
            if (scramble) begin
                Operand1 = $urandom;
                Operand2 = $urandom;
                MCycleOp = 1'($urandom);
            end
            #1;
            if (!Busy) begin
                done = 1'b1;
            end else begin
                busy_cyc++;
                if (Result1 !== r1s || Result2 !== r2s) leaked = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1; Start = 1'b0; MCycleOp = 1'b0; Operand1 = '0; Operand2 = '0;
        #12;
        compared++;
        if (Busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b want 0", Busy); end
        compared++;
        if (Result1 !== 32'h0) begin mismatched++; $display("FAIL reset_r1: got %h want 0", Result1); end
        compared++;
        if (Result2 !== 32'h0) begin mismatched++; $display("FAIL reset_r2: got %h want 0", Result2); end
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK); #1;
        compared++;
        if (Busy !== 1'b0) begin mismatched++; $display("FAIL idle_busy: got %b want 0", Busy); end
    endtask

    task automatic test_directed();
        logic        op_t [5];
        logic [31:0] a_t  [5];
        logic [31:0] b_t  [5];
        logic [31:0] e1_t [5];
        logic [31:0] e2_t [5];
        int busy_cyc; bit leaked; bit done;
        op_t[0] = 0; a_t[0] = 32'd7;          b_t[0] = 32'd6;          e1_t[0] = 32'h0000_002A; e2_t[0] = 32'h0;
        op_t[1] = 0; a_t[1] = 32'hFFFF_FFFF;  b_t[1] = 32'hFFFF_FFFF;  e1_t[1] = 32'h0000_0001; e2_t[1] = 32'hFFFF_FFFE;
        op_t[2] = 1; a_t[2] = 32'd100;        b_t[2] = 32'd7;          e1_t[2] = 32'd14;        e2_t[2] = 32'd2;
        op_t[3] = 1; a_t[3] = 32'h8000_0000;  b_t[3] = 32'd3;          e1_t[3] = 32'h2AAA_AAAA; e2_t[3] = 32'd2;
        op_t[4] = 1; a_t[4] = 32'h0000_1234;  b_t[4] = 32'd0;          e1_t[4] = 32'hFFFF_FFFF; e2_t[4] = 32'h0000_1234;
        for (int k = 0; k < 5; k++) begin
            issue(op_t[k], a_t[k], b_t[k]);
            wait_done(1'b0, 1'b0, busy_cyc, leaked, done);
            compared++;
            if (!done) begin mismatched++; $display("FAIL dir%0d_timeout: Busy never dropped", k); end
            compared++;
            if (busy_cyc != 33) begin mismatched++; $display("FAIL dir%0d_busy_cycles: got %0d want 33", k, busy_cyc); end
            compared++;
            if (leaked) begin mismatched++; $display("FAIL dir%0d_early_result: outputs changed while busy", k); end
            compared++;
            if (Result1 !== e1_t[k]) begin mismatched++; $display("FAIL dir%0d_r1: got %h want %h", k, Result1, e1_t[k]); end
            compared++;
            if (Result2 !== e2_t[k]) begin mismatched++; $display("FAIL dir%0d_r2: got %h want %h", k, Result2, e2_t[k]); end
            @(negedge CLK); #1;
            compared++;
            if (Busy !== 1'b0 || Result1 !== e1_t[k]) begin
                mismatched++; $display("FAIL dir%0d_hold: busy %b r1 %h want 0 / %h", k, Busy, Result1, e1_t[k]);
            end
        end
    endtask

    task automatic test_random();
        int busy_cyc; bit leaked; bit done;
        logic op; logic [31:0] a, b; logic [63:0] exp;
        for (int k = 0; k < 24; k++) begin
            op  = 1'($urandom);
            a   = pick_operand();
            b   = pick_operand();
            exp = model(op, a, b);
            issue(op, a, b);
            wait_done(1'b0, 1'b1, busy_cyc, leaked, done);
            compared++;
            if (!done || busy_cyc != 33 || leaked) begin
                mismatched++;
                $display("FAIL rnd%0d_timing: done %b busy_cycles %0d leaked %b want 1/33/0", k, done, busy_cyc, leaked);
            end
            compared++;
            if ({Result2, Result1} !== exp) begin
                mismatched++;
                $display("FAIL rnd%0d_result: op %b a %h b %h got %h_%h want %h", k, op, a, b, Result2, Result1, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        int busy_cyc; bit leaked; bit done;
        logic op1, op2; logic [31:0] a, b, c, d; logic [63:0] exp1, exp2;
        op1 = 1'b1; a = pick_operand(); b = pick_operand(); exp1 = model(op1, a, b);
        op2 = 1'b0; c = pick_operand(); d = pick_operand(); exp2 = model(op2, c, d);
        issue(op1, a, b);
        wait_done(1'b1, 1'b1, busy_cyc, leaked, done);
        compared++;
        if (!done || busy_cyc != 33) begin mismatched++; $display("FAIL b2b_first_timing: done %b busy_cycles %0d want 1/33", done, busy_cyc); end
        compared++;
        if ({Result2, Result1} !== exp1) begin mismatched++; $display("FAIL b2b_first_result: got %h_%h want %h", Result2, Result1, exp1); end
        MCycleOp = op2; Operand1 = c; Operand2 = d;
        @(negedge CLK); #1;
        compared++;
        if (Busy !== 1'b1) begin mismatched++; $display("FAIL b2b_restart: busy got %b want 1 one cycle after DONE", Busy); end
        wait_done(1'b1, 1'b1, busy_cyc, leaked, done);
        compared++;
        if (!done || busy_cyc != 33 || leaked) begin
            mismatched++; $display("FAIL b2b_second_timing: done %b busy_cycles %0d leaked %b want 1/33/0", done, busy_cyc, leaked);
        end
        compared++;
        if ({Result2, Result1} !== exp2) begin mismatched++; $display("FAIL b2b_second_result: got %h_%h want %h", Result2, Result1, exp2); end
        Start = 1'b0;
        @(negedge CLK); #1;
        compared++;
        if (Busy !== 1'b0) begin mismatched++; $display("FAIL b2b_stop: busy got %b want 0", Busy); end
    endtask

    task automatic test_reset_mid();
        int busy_cyc; bit leaked; bit done;
        issue(1'b0, 32'd7, 32'd6);
        wait_done(1'b0, 1'b0, busy_cyc, leaked, done);
        issue(1'b1, 32'hDEAD_BEEF, 32'd13);
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            Start = 1'b0;
        end
        #1;
        compared++;
        if (Busy !== 1'b1) begin mismatched++; $display("FAIL mid_busy_before: got %b want 1", Busy); end
        RESET = 1'b1;
        #1;
        compared++;
        if (Busy !== 1'b0) begin mismatched++; $display("FAIL mid_busy_async: got %b want 0", Busy); end
        compared++;
        if (Result1 !== 32'h0 || Result2 !== 32'h0) begin
            mismatched++; $display("FAIL mid_results_async: got %h_%h want 0_0", Result2, Result1);
        end
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK); #1;
            compared++;
            if (Busy !== 1'b0 || Result1 !== 32'h0 || Result2 !== 32'h0) begin
                mismatched++; $display("FAIL mid_stay_idle%0d: busy %b results %h_%h want 0 / 0_0", k, Busy, Result2, Result1);
            end
        end
        issue(1'b0, 32'd3, 32'd5);
        wait_done(1'b0, 1'b0, busy_cyc, leaked, done);
        compared++;
        if (!done || busy_cyc != 33) begin mismatched++; $display("FAIL mid_after_timing: done %b busy_cycles %0d want 1/33", done, busy_cyc); end
        compared++;
        if (Result1 !== 32'd15 || Result2 !== 32'd0) begin
            mismatched++; $display("FAIL mid_after_result: got %h_%h want 0_f", Result2, Result1);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mcycle_unit.md
Name: mcycle_unit

Overview:
Multi-cycle unsigned multiply/divide unit in the EX stage. It is driven by the decoder's M_Start and MCycleOp outputs and by the register-file operands. It stalls the pipeline through Busy while an iterative operation runs. When it finishes, it holds two result words; the decoder's M_W steers one of them to register write-back.

Parameters:
WIDTH, 32, operand and result word width in bits (must be ≥ 2).

Ports:
CLK  input  1  system clock; all state updates on the rising edge.
RESET  input  1  asynchronous, active-high reset.
Start  input  1  request a new operation (decoder M_Start).
MCycleOp  input  1  operation select: 0 = unsigned multiply, 1 = unsigned divide.
Operand1  input  WIDTH  multiplicand / dividend.
Operand2  input  WIDTH  multiplier / divisor.
Result1  output  WIDTH  multiply: low product word; divide: quotient.
Result2  output  WIDTH  multiply: high product word; divide: remainder.
Busy  output  1  stall request to the hazard/pipeline logic.

Behaviour:
- Reset (asynchronous, any state):
  - state = IDLE.
  - Result1 = 0, Result2 = 0, iteration counter = 0, internal operand/accumulator registers = 0.
  - Busy drops to 0 immediately, including when reset arrives mid-operation.
  - The aborted operation leaves no trace.
- States:
  - IDLE: waits for Start.
  - COMPUTING: one iteration per cycle.
  - DONE: one-cycle cool-down.
- Busy is combinational: Busy = (state==IDLE & Start) | (state==COMPUTING).
  - Busy rises in the same cycle Start is first seen, so the issuing instruction stalls at once.
  - Busy = 0 in DONE.
- IDLE:
  - Start=1 at the edge: latch Operand1, Operand2 and MCycleOp, clear the accumulator, set counter = 0, go to COMPUTING.
  - Start=0: stay in IDLE; results hold.
- Operands and MCycleOp are sampled only at the IDLE→COMPUTING edge. Input changes afterwards have no effect.
- COMPUTING:
  - Performs exactly WIDTH iterations, counter 0..WIDTH-1.
  - On the edge where counter == WIDTH-1, load the final values into Result1/Result2 and go to DONE.
  - Start is ignored throughout.
- Multiply (MCycleOp = 0):
  - Radix-2 shift-add over a 2·WIDTH-bit product.
  - Product = Operand1 × Operand2, unsigned, no truncation.
  - Result1 = product[WIDTH-1:0], Result2 = product[2·WIDTH-1:WIDTH].
- Divide (MCycleOp = 1):
  - Restoring division, one quotient bit per iteration, MSB first.
  - Result1 = floor(Operand1 / Operand2), Result2 = Operand1 mod Operand2.
- Divide by zero:
  - No special path; the restoring algorithm naturally yields Result1 = all ones and Result2 = Operand1.
  - No trap or flag.
- DONE:
  - Lasts exactly one cycle, then goes to IDLE unconditionally.
  - Start is ignored in DONE. This lets the stalled instruction advance while Start is still asserted, without re-triggering.
- Latency:
  - Start seen in cycle 0; Busy high for cycles 0..WIDTH (WIDTH+1 cycles).
  - Results valid from cycle WIDTH+1 (the DONE cycle).
  - Results hold until the next completion or reset.
- Back-to-back operations: Start high in the cycle after DONE (state IDLE) launches a new operation. Minimum issue interval is WIDTH+2 cycles.
- Result1/Result2 change only at completion. Intermediate accumulator values are never visible on the outputs.
- Counter width is clog2(WIDTH). No wrap-around occurs because the exit is at WIDTH-1.

Test Plan (all with WIDTH=32):
- Multiply small values: Start=1, MCycleOp=0, Operand1=7, Operand2=6.
  - Busy=1 for 33 cycles starting in the Start cycle.
  - In DONE: Result1=0x0000002A, Result2=0x00000000, Busy=0.
- Multiply maximum values: Operand1 = Operand2 = 0xFFFFFFFF, MCycleOp=0 → Result1=0x00000001, Result2=0xFFFFFFFE.
- Divide: MCycleOp=1, Operand1=100, Operand2=7 → Result1=14, Result2=2. Also 0x80000000 / 0x00000003 → Result1=0x2AAAAAAA, Result2=2.
- Divide by zero: Operand1=0x00001234, Operand2=0 → Result1=0xFFFFFFFF, Result2=0x00001234, completing in the normal 33 Busy cycles.
- Start held high continuously with operands changed mid-operation:
  - Results reflect only the originally latched operands.
  - Busy=0 for exactly one cycle (DONE), then a second operation starts and Busy is high again.
- Reset mid-operation: assert RESET in the 10th COMPUTING cycle of a divide.
  - Busy→0 and Result1=Result2=0 asynchronously.
  - After release with Start=0, the unit stays in IDLE.
  - A following 3×5 returns Result1=15, Result2=0.
